// File: rtl/inst_sram_axi_rd.sv
// Instruction-side sram-like to AXI read bridge: single-beat reads, returned in request
// order, with up to MAX_OUTSTANDING requests in flight.
module inst_sram_axi_rd #(
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter logic [3:0]  AXI_ID          = 4'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inst_sram_req,
   input  logic        inst_sram_wr,
   input  logic [1:0]  inst_sram_size,
   input  logic        inst_sram_cached,
   input  logic [31:0] inst_sram_addr,
   input  logic [3:0]  inst_sram_wstrb,
   input  logic [31:0] inst_sram_wdata,
   output logic        inst_sram_addr_ok,
   output logic        inst_sram_data_ok,
   output logic [31:0] inst_sram_rdata,
   output logic        bus_error,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [3:0]  arcache,
   output logic        arvalid,
   input  logic        arready,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready
);

   localparam int unsigned     CntW   = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_OUTSTANDING);

   logic [CntW-1:0] count_q, count_d;
   logic            arvalid_q, arvalid_d;
   logic [31:0]     araddr_q, araddr_d;
   logic [2:0]      arsize_q, arsize_d;
   logic [3:0]      arcache_q, arcache_d;
   logic            data_ok_q;
   logic            bus_error_q;
   logic [31:0]     rdata_q;
   logic            accept;
   logic            r_hs;
   logic            unused_inputs;

   assign unused_inputs = ^{inst_sram_wstrb, inst_sram_wdata, rlast};

   assign rready = ~reset;
   assign r_hs   = rvalid & rready;
   assign accept = inst_sram_req & ~inst_sram_wr & ~reset & (~arvalid_q | arready) &
                   (count_q < MaxCnt);

   // A slot is released at the R handshake, so a request can be accepted in the
   // same cycle as the data_ok that frees it.
   always_comb begin
      arvalid_d = arvalid_q;
      araddr_d  = araddr_q;
      arsize_d  = arsize_q;
      arcache_d = arcache_q;
      count_d   = count_q;

      if (accept) begin
         arvalid_d = 1'b1;
         araddr_d  = inst_sram_addr;
         arsize_d  = {1'b0, inst_sram_size};
         arcache_d = inst_sram_cached ? 4'b1111 : 4'b0000;
      end else if (arvalid_q && arready) begin
         arvalid_d = 1'b0;
      end

      unique case ({accept, r_hs})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q     <= '0;
         arvalid_q   <= 1'b0;
         araddr_q    <= '0;
         arsize_q    <= '0;
         arcache_q   <= '0;
         data_ok_q   <= 1'b0;
         bus_error_q <= 1'b0;
         rdata_q     <= '0;
      end else begin
         count_q     <= count_d;
         arvalid_q   <= arvalid_d;
         araddr_q    <= araddr_d;
         arsize_q    <= arsize_d;
         arcache_q   <= arcache_d;
         data_ok_q   <= r_hs;
         bus_error_q <= r_hs & (rresp != 2'b00);
         if (r_hs) begin
            rdata_q <= rdata;
         end
      end
   end

   assign inst_sram_addr_ok = accept;
   assign inst_sram_data_ok = data_ok_q;
   assign inst_sram_rdata   = rdata_q;
   assign bus_error         = bus_error_q;
   assign arid              = AXI_ID;
   assign araddr            = araddr_q;
   assign arlen             = 8'd0;
   assign arsize            = arsize_q;
   assign arcache           = arcache_q;
   assign arvalid           = arvalid_q;

endmodule

// File: tb/tb_inst_sram_axi_rd.sv
// Bench for inst_sram_axi_rd: queue-based reference model, randomized AXI slave,
// directed scenarios with literal expectations.
module tb_inst_sram_axi_rd;

   localparam int unsigned MAX = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        inst_sram_req, inst_sram_wr, inst_sram_cached;
   logic [1:0]  inst_sram_size;
   logic [31:0] inst_sram_addr, inst_sram_wdata;
   logic [3:0]  inst_sram_wstrb;
   logic        inst_sram_addr_ok, inst_sram_data_ok, bus_error;
   logic [31:0] inst_sram_rdata;
   logic [3:0]  arid, arcache;
   logic [31:0] araddr, rdata;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic        arvalid, arready, rlast, rvalid, rready;
   logic [1:0]  rresp;

   always #5 clk = ~clk;

   inst_sram_axi_rd #(.MAX_OUTSTANDING(MAX), .AXI_ID(4'd0)) dut (
      .clk(clk), .reset(reset),
      .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
      .inst_sram_size(inst_sram_size), .inst_sram_cached(inst_sram_cached),
      .inst_sram_addr(inst_sram_addr), .inst_sram_wstrb(inst_sram_wstrb),
      .inst_sram_wdata(inst_sram_wdata), .inst_sram_addr_ok(inst_sram_addr_ok),
      .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
      .bus_error(bus_error), .arid(arid), .araddr(araddr), .arlen(arlen),
      .arsize(arsize), .arcache(arcache), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   typedef struct { logic [31:0] addr; logic [1:0] size; logic cached; } req_t;
   typedef struct { logic [31:0] addr; int due; } sresp_t;

   req_t        acc_q[$];        // accepted, R beat not yet received
   req_t        pend;            // accepted, AR not yet handshaken
   bit          pend_valid = 0;
   sresp_t      sq[$];           // slave: AR seen, R beat pending
   bit          exp_data_ok = 0, exp_berr = 0;
   logic [31:0] exp_rdata = '0, exp_araddr = '0;

   int n_checks = 0, n_fail = 0, cyc = 0;
   bit checking = 0, force_err = 0;
   int ar_pct = 100, rd_min = 0, rd_max = 0, err_pct = 0;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return a ^ 32'h23DD_0001;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model and slave bookkeeping: inputs are stable here, outputs settled.
   always @(negedge clk) begin : model
      bit   exp_ok;
      req_t cur, r;
      cur    = '{inst_sram_addr, inst_sram_size, inst_sram_cached};
      exp_ok = inst_sram_req && !inst_sram_wr && !reset && (!pend_valid || arready) &&
               (acc_q.size() < MAX);
      if (checking) begin
         chk("addr_ok", inst_sram_addr_ok, exp_ok);
         chk("rready", rready, !reset);
         chk("arvalid", arvalid, pend_valid);
         chk("araddr", araddr, exp_araddr);
         chk("arid", arid, 0);
         chk("arlen", arlen, 0);
         chk("data_ok", inst_sram_data_ok, exp_data_ok);
         chk("rdata", inst_sram_rdata, exp_rdata);
         chk("bus_error", bus_error, exp_berr);
         if (pend_valid) begin
            chk("arsize", arsize, {1'b0, pend.size});
            chk("arcache", arcache, pend.cached ? 4'b1111 : 4'b0000);
         end
      end
      if (reset) begin
         acc_q.delete();
         sq.delete();
         pend_valid  = 0;
         exp_data_ok = 0;
         exp_berr    = 0;
         exp_rdata   = '0;
         exp_araddr  = '0;
      end else begin
         exp_data_ok = 0;
         exp_berr    = 0;
         if (rvalid) begin
            if (checking) chk("rvalid_with_outstanding", acc_q.size() > 0, 1);
            if (acc_q.size() > 0) begin
               r           = acc_q.pop_front();
               exp_data_ok = 1;
               exp_rdata   = mem(r.addr);
               exp_berr    = (rresp != 2'b00);
            end
            if (sq.size() > 0) void'(sq.pop_front());
         end
         if (pend_valid && arready) pend_valid = 0;
         if (exp_ok) begin
            acc_q.push_back(cur);
            pend       = cur;
            pend_valid = 1;
            exp_araddr = cur.addr;
         end
         if (arvalid && arready)
            sq.push_back('{araddr, cyc + 1 + int'($urandom_range(rd_min, rd_max))});
      end
   end

   // Advance one cycle and drive the slave side for it.
   task automatic step();
      @(posedge clk);
      cyc++;
      #1;
      arready = ($urandom_range(1, 100) <= ar_pct);
      if (!reset && sq.size() > 0 && sq[0].due <= cyc) begin
         rvalid = 1'b1;
         rdata  = mem(sq[0].addr);
         rresp  = (force_err || $urandom_range(1, 100) <= err_pct) ? 2'b10 : 2'b00;
      end else begin
         rvalid = 1'b0;
         rdata  = $urandom;
         rresp  = 2'b00;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         inst_sram_req = 1'b0;
         inst_sram_wr  = 1'b0;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] t2_addr[3];
      int          idx, ndok, t_acc[3], t_dok;
      logic [31:0] first_rd;
      bit          seen;

      reset = 1'b1; inst_sram_req = 1'b0; inst_sram_wr = 1'b0; inst_sram_size = 2'd2;
      inst_sram_cached = 1'b0; inst_sram_addr = '0; inst_sram_wstrb = '0;
      inst_sram_wdata = '0; arready = 1'b0; rdata = '0; rresp = '0; rlast = 1'b1;
      rvalid = 1'b0;
      step(); step();
      checking = 1;
      step();
      reset = 1'b0;
      idle(2);

      // 1: zero-wait fetch; addr is the physical form of kseg1 0xBFC00000
      ar_pct = 100; rd_min = 0; rd_max = 0;
      step();
      inst_sram_req = 1'b1; inst_sram_addr = 32'h1FC0_0000; inst_sram_cached = 1'b0;
      inst_sram_size = 2'd2;
      @(negedge clk); chk("t1_addr_ok_T0", inst_sram_addr_ok, 1);
      step(); inst_sram_req = 1'b0;
      @(negedge clk);
      chk("t1_arvalid_T1", arvalid, 1);
      chk("t1_araddr", araddr, 32'h1FC0_0000);
      chk("t1_arcache", arcache, 4'b0000);
      chk("t1_arsize", arsize, 3'd2);
      step(); @(negedge clk); chk("t1_no_data_ok_T2", inst_sram_data_ok, 0);
      step(); @(negedge clk);
      chk("t1_data_ok_T3", inst_sram_data_ok, 1);
      chk("t1_rdata", inst_sram_rdata, 32'h3C1D_0001);
      step(); @(negedge clk); chk("t1_data_ok_one_cycle", inst_sram_data_ok, 0);
      idle(3);

      // 2: three back-to-back fetches, slave R delayed by 5 cycles
      t2_addr[0] = 32'h100; t2_addr[1] = 32'h104; t2_addr[2] = 32'h108;
      rd_min = 5; rd_max = 5; idx = 0; ndok = 0; t_dok = -1; first_rd = '0;
      for (int c = 0; c < 40 && (idx < 3 || ndok < 3); c++) begin
         step();
         inst_sram_req = (idx < 3);
         if (idx < 3) inst_sram_addr = t2_addr[idx];
         @(negedge clk);
         if (inst_sram_addr_ok && idx < 3) begin t_acc[idx] = c; idx++; end
         if (inst_sram_data_ok) begin
            if (ndok == 0) begin t_dok = c; first_rd = inst_sram_rdata; end
            ndok++;
         end
      end
      chk("t2_accepted", idx, 3);
      chk("t2_data_ok_count", ndok, 3);
      chk("t2_third_accept_delay", t_acc[2] - t_acc[0], 8);
      chk("t2_third_with_first_data_ok", t_acc[2], t_dok);
      chk("t2_first_rdata", first_rd, 32'h23DD_0101);
      idle(3);

      // 3: arready low for 4 cycles with a second request held
      rd_min = 0; rd_max = 0; ar_pct = 0;
      step(); inst_sram_req = 1'b1; inst_sram_addr = 32'h400; inst_sram_cached = 1'b1;
      @(negedge clk); chk("t3_first_accept", inst_sram_addr_ok, 1);
      for (int c = 0; c < 4; c++) begin
         step(); inst_sram_addr = 32'h404;
         @(negedge clk);
         chk("t3_addr_ok_blocked", inst_sram_addr_ok, 0);
         chk("t3_araddr_stable", araddr, 32'h400);
         chk("t3_arcache_cached", arcache, 4'b1111);
      end
      ar_pct = 100;
      step(); @(negedge clk); chk("t3_accept_on_arready", inst_sram_addr_ok, 1);
      step(); inst_sram_req = 1'b0;
      @(negedge clk); chk("t3_second_araddr", araddr, 32'h404);
      idle(6);

      // 4: error response
      force_err = 1; seen = 0;
      step(); inst_sram_req = 1'b1; inst_sram_addr = 32'h200;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         if (inst_sram_data_ok) begin
            seen = 1;
            chk("t4_bus_error", bus_error, 1);
            chk("t4_rdata", inst_sram_rdata, 32'h23DD_0201);
         end else begin
            step(); inst_sram_req = 1'b0;
         end
      end
      chk("t4_data_ok_seen", seen, 1);
      force_err = 0;
      idle(2);
      chk("t4_outstanding_freed", acc_q.size(), 0);

      // 5: reset with two requests outstanding
      rd_min = 20; rd_max = 20;
      step(); inst_sram_req = 1'b1; inst_sram_addr = 32'h500;
      step(); inst_sram_addr = 32'h504;
      step(); step();
      reset = 1'b1;
      @(negedge clk);
      chk("t5_addr_ok_in_reset", inst_sram_addr_ok, 0);
      chk("t5_rready_in_reset", rready, 0);
      step(); reset = 1'b0; inst_sram_req = 1'b0;
      @(negedge clk);
      chk("t5_arvalid_cleared", arvalid, 0);
      chk("t5_araddr_cleared", araddr, 0);
      chk("t5_rdata_cleared", inst_sram_rdata, 0);
      chk("t5_data_ok_cleared", inst_sram_data_ok, 0);
      chk("t5_rready_after", rready, 1);
      rd_min = 0; rd_max = 0; seen = 0;
      step(); inst_sram_req = 1'b1; inst_sram_addr = 32'h300;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         if (inst_sram_data_ok) begin
            seen = 1;
            chk("t5_new_rdata", inst_sram_rdata, 32'h23DD_0301);
         end else begin
            step(); inst_sram_req = 1'b0;
         end
      end
      chk("t5_new_request_done", seen, 1);
      idle(25);

      // 6: write requests are never accepted
      for (int c = 0; c < 10; c++) begin
         step(); inst_sram_req = 1'b1; inst_sram_wr = 1'b1;
         inst_sram_addr = 32'h600 + 32'(c * 4);
         @(negedge clk);
         chk("t6_addr_ok", inst_sram_addr_ok, 0);
         chk("t6_arvalid", arvalid, 0);
      end
      idle(2);

      // Random traffic
      for (int blk = 0; blk < 15; blk++) begin
         ar_pct  = $urandom_range(30, 100);
         rd_min  = 0;
         rd_max  = $urandom_range(0, 6);
         err_pct = $urandom_range(0, 25);
         for (int c = 0; c < 200; c++) begin
            step();
            reset            = ($urandom_range(0, 499) == 0);
            inst_sram_req    = $urandom_range(0, 1);
            inst_sram_wr     = ($urandom_range(0, 9) == 0);
            inst_sram_size   = 2'($urandom_range(0, 2));
            inst_sram_cached = $urandom_range(0, 1);
            inst_sram_addr   = {$urandom} & 32'hFFFF_FFFC;
            inst_sram_wstrb  = 4'($urandom);
            inst_sram_wdata  = $urandom;
         end
      end
      reset = 1'b0; ar_pct = 100; err_pct = 0;
      idle(40);
      chk("drain_all_returned", acc_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
